// File: rtl/gp_audio_pkg.sv
// Shared audio-path definitions: sample/slot/frame geometry, the PCM sample
// type and the transmit holding-buffer states.
package gp_audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned SLOT_BITS  = 16;
  localparam int unsigned FRAME_BITS = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // One-deep holding buffer between the effects chain and the serializer.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV to form bclk and strobes
// fall_evt for one clk in the cycle whose edge drives bclk from 1 to 0.
module i2s_clk_div #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_evt
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_term;

  assign div_term = (div_cnt == DIV_LAST);
  assign fall_evt = div_term & bclk;

  // Half-period counter; bclk toggles at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_term) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: accepts mono PCM samples through a one-deep buffer and
// serializes each as a stereo frame (same sample on both channels), MSB
// first, with the standard one-bit lrclk delay.
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add the saturating
// underrun_cnt output.
module i2s_tx #(
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned SAMPLE_W = gp_audio_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_tick
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  import gp_audio_pkg::*;

  localparam int unsigned SLOTS = 2 * SAMPLE_W;
  localparam int unsigned K_W   = $clog2(SLOTS);
  localparam int unsigned IDX_W = $clog2(SAMPLE_W);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(SLOTS - 1);
  localparam logic [K_W-1:0]   K_RIGHT  = K_W'(SAMPLE_W - 1);
  localparam logic [K_W-1:0]   K_SLOT_W = K_W'(SAMPLE_W);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(SAMPLE_W - 1);

  logic                fall_evt;
  logic [K_W-1:0]      k;
  logic [K_W-1:0]      k_next;
  logic [K_W-1:0]      slot_pos;
  logic [IDX_W-1:0]    bit_idx;
  logic [SAMPLE_W-1:0] frame;
  logic [SAMPLE_W-1:0] frame_next;
  logic [SAMPLE_W-1:0] buf_data;
  buf_state_t          buf_state;
  buf_state_t          buf_state_next;
  logic                load;
  logic                accept;
  logic                lrclk_next;
  logic                sdata_next;

  i2s_clk_div #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  // Slot advance, frame load, buffer next-state and next serial outputs.
  // The serial bit for the slot being entered is taken from frame_next so
  // the MSB of a freshly loaded frame leaves on the same falling event.
  always_comb begin
    k_next         = k;
    load           = 1'b0;
    accept         = sample_valid & sample_ready;
    frame_next     = frame;
    buf_state_next = buf_state;

    if (fall_evt) begin
      k_next = (k == K_LAST) ? '0 : k + 1'b1;
      load   = (k == K_LAST);
    end

    if (load && (buf_state == BUF_FULL)) begin
      frame_next = buf_data;
    end

    if (accept) begin
      buf_state_next = BUF_FULL;
    end else if (load) begin
      buf_state_next = BUF_EMPTY;
    end

    slot_pos   = (k_next >= K_SLOT_W) ? k_next - K_SLOT_W : k_next;
    bit_idx    = IDX_MSB - IDX_W'(slot_pos);
    sdata_next = frame_next[bit_idx];
    lrclk_next = (k_next >= K_RIGHT) && (k_next != K_LAST);
  end

  // Holding buffer, frame register and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state    <= BUF_EMPTY;
      buf_data     <= '0;
      frame        <= '0;
      sample_ready <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      buf_state    <= buf_state_next;
      frame        <= frame_next;
      sample_ready <= (buf_state_next == BUF_EMPTY);
      frame_tick   <= load;
      if (accept) begin
        buf_data <= sample;
      end
    end
  end

  // Slot counter and serial outputs, updated only on falling bclk events.
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= K_LAST;
      lrclk <= 1'b0;
      sdata <= 1'b0;
    end else if (fall_evt) begin
      k     <= k_next;
      lrclk <= lrclk_next;
      sdata <= sdata_next;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Saturating count of frame loads that found the buffer empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (load && (buf_state == BUF_EMPTY) && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with BCLK_DIV=2 (bclk period 4 clk, frame 128 clk).
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_tick;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int n_edges;
  int rdy_cnt;

  i2s_tx #(
    .BCLK_DIV (2),
    .SAMPLE_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_tick   (frame_tick)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance clk edges until frame_tick is seen; returns the edge count, 0 on timeout.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (frame_tick) begin
        n = i;
        break;
      end
    end
  endtask

  // Called just after a load edge; captures one frame and ends just after the next load edge.
  task automatic run_frame(input string tag, input logic [15:0] exp_word, input int sw_e,
                           input logic sw_valid, input logic [15:0] sw_sample,
                           output int ready_cnt);
    logic [15:0] left;
    logic [15:0] right;
    logic [31:0] lr;
    int          ticks;
    left = '0;
    right = '0;
    lr = '0;
    ticks = 0;
    ready_cnt = 0;
    for (int e = 0; e < 128; e++) begin
      if (e % 4 == 0) begin
        int kk;
        kk = e / 4;
        if (kk < 16) left[15-kk] = sdata;
        else         right[31-kk] = sdata;
        lr[kk] = lrclk;
      end
      if (e == sw_e) begin
        sample_valid = sw_valid;
        sample       = sw_sample;
      end
      @(posedge clk);
      #1;
      if (e < 127) begin
        ticks     += int'(frame_tick);
        ready_cnt += int'(sample_ready);
      end
    end
    chk({tag, "_left"},  {16'h0, left},  {16'h0, exp_word});
    chk({tag, "_right"}, {16'h0, right}, {16'h0, exp_word});
    chk({tag, "_lrclk"}, lr, 32'h7FFF_8000);
    chk({tag, "_extra_ticks"}, ticks, 0);
    chk({tag, "_next_tick"}, {31'h0, frame_tick}, 1);
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_outputs", {27'h0, bclk, lrclk, sdata, frame_tick, sample_ready}, 0);
    end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("reset_underrun", {16'h0, underrun_cnt}, 0);
`endif
    rst = 1'b0;

    @(posedge clk);
    #1;
    chk("ready_after_reset", {31'h0, sample_ready}, 1);
    sample_valid = 1'b1;
    sample       = 16'hA5C3;
    @(posedge clk);
    #1;
    chk("ready_drops_on_accept", {31'h0, sample_ready}, 0);
    sample_valid = 1'b0;

    wait_tick(n_edges);
    chk("first_load_edge", n_edges, 2);

    run_frame("f1_a5c3", 16'hA5C3, -1, 1'b0, 16'h0, rdy_cnt);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_after_f2_load", {16'h0, underrun_cnt}, 1);
`endif
    run_frame("f2_repeat", 16'hA5C3, -1, 1'b0, 16'h0, rdy_cnt);

    sample_valid = 1'b1;
    sample       = 16'h8000;
    run_frame("f3_repeat", 16'hA5C3, 1, 1'b1, 16'h7FFF, rdy_cnt);
    chk("f3_ready_held_low", rdy_cnt, 0);
    run_frame("f4_8000", 16'h8000, 1, 1'b0, 16'h0, rdy_cnt);

    run_frame("f5_7fff", 16'h7FFF, 127, 1'b1, 16'h1234, rdy_cnt);
    sample_valid = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_load_cycle_offer", {16'h0, underrun_cnt}, 3);
`endif
    run_frame("f6_hold_7fff", 16'h7FFF, -1, 1'b0, 16'h0, rdy_cnt);
    run_frame("f7_1234", 16'h1234, -1, 1'b0, 16'h0, rdy_cnt);

    sample_valid = 1'b1;
    sample       = 16'h00FF;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    chk("f8_buffered_ready", {31'h0, sample_ready}, 0);
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midframe_reset_outputs", {27'h0, bclk, lrclk, sdata, frame_tick, sample_ready}, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("midframe_reset_underrun", {16'h0, underrun_cnt}, 0);
`endif
    rst = 1'b0;

    wait_tick(n_edges);
    chk("load_after_midframe_reset", n_edges, 4);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_after_midframe_reset", {16'h0, underrun_cnt}, 1);
`endif
    run_frame("f_post_reset", 16'h0000, -1, 1'b0, 16'h0, rdy_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 4: clk cycles per bclk half-period; legal range is 2 or more.
REQ-002 Parameter SAMPLE_W, default 16: sample width in bits; it equals the slot width.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sample_valid  input  1  upstream sample present.
REQ-006 sample  input  16  signed PCM sample from the effects chain.
REQ-007 sample_ready  output  1  one-deep holding buffer empty; accept allowed.
REQ-008 bclk  output  1  I2S bit clock.
REQ-009 lrclk  output  1  I2S word select: 0 = left, 1 = right.
REQ-010 sdata  output  1  I2S serial data, MSB first.
REQ-011 frame_tick  output  1  one-clk pulse on each frame load.

Function
REQ-012 Division counter shall count 0..BCLK_DIV-1; bclk shall toggle at terminal count; a falling event is a terminal count while bclk=1.
REQ-013 Slot index k (0..31) shall advance modulo 32 on each falling event; sdata and lrclk shall change only on falling events.
REQ-014 lrclk shall be 0 for k in {31, 0..14} and 1 for k in 15..30, giving the standard one-bit I2S delay.
REQ-015 sdata shall be frame[15-k] for k 0..15 and frame[31-k] for k 16..31; the mono sample is duplicated into both channels.
REQ-016 Handshake: sample is accepted when sample_valid && sample_ready; the buffer becomes full and sample_ready drops next cycle.
REQ-017 Frame load occurs in the clk cycle of the falling event entering k=0.
  - Buffer full: the buffer shall move to the frame register, the buffer shall empty, and frame_tick=1.
  - Buffer empty (underrun): the frame register shall hold its previous value and frame_tick=1.
REQ-018 Load and accept in the same cycle: the load uses the buffer contents at the start of the cycle; a newly accepted sample shall remain in the buffer for the next frame.
REQ-019 Latency: an accepted sample's MSB shall appear on sdata at the next entry to k=0.
REQ-020 Arithmetic shall be unsigned counters only; there shall be no sample modification.

Reset
REQ-021 While rst=1, the next clk edge shall set:
  - bclk=0, lrclk=0, sdata=0, frame_tick=0, sample_ready=0;
  - divider=0, k=31, frame register=0, buffer empty.
REQ-022 sample_ready shall be 1 on the first cycle after rst deasserts.
REQ-023 Reset mid-frame shall abort the frame and discard a buffered sample; the first falling event after reset shall enter k=0 and load.

Configuration
REQ-024 Macro I2S_TX_UNDERRUN_CNT_EN, when defined, shall add output underrun_cnt[15:0].
  - It shall increment on each underrun load (REQ-017), saturate at 0xFFFF, and reset to 0.
  - When undefined, the port and its logic shall be absent and all other behaviour shall be identical.

Structure
REQ-025 Shared package gp_audio_pkg shall hold:
  - SAMPLE_W=16, SLOT_BITS=16, FRAME_BITS=32;
  - typedef sample_t (signed 16-bit).
REQ-026 Sub-module i2s_clk_div shall generate bclk and the falling-event strobe; slot, buffer and shift logic shall stay in i2s_tx.

Verification (BCLK_DIV=2, bclk period 4 clk, frame 128 clk)
REQ-027 Hold rst for 3 clk -> all outputs 0 during reset; sample_ready=1 on the first cycle after deassertion.
REQ-028 Send 0xA5C3 once -> sdata gives 1010010111000011 for k 0..15 and again for k 16..31; lrclk falls with the right-channel LSB at k=31; frame_tick pulses once.
REQ-029 No sample offered for the following frame -> 0xA5C3 repeats; underrun_cnt=1 with macro defined.
REQ-030 sample_valid held with 0x8000 then 0x7FFF -> 0x8000 accepted; sample_ready stays low until the next load; 0x7FFF is serialized in the frame after 0x8000.
REQ-031 Offer 0x1234 in the exact load cycle with the buffer empty -> underrun counted; 0x1234 appears in the following frame.
REQ-032 Assert rst at k=8 with 0x00FF buffered -> outputs 0 on the next clk; after release, the first frame is 0x0000 (buffer discarded).
